nat_conn_tracker: RTL and testbench

NAT_CONN_TRACKER -- requirements
Module: nat_conn_tracker

---
 rtl/nat_pkg.sv | 29 ++
 rtl/nat_conn_tracker_if.sv | 11 +
 rtl/nat_conn_mem.sv | 45 ++++
 rtl/nat_conn_tracker.sv | 155 +++++++++++++++
 tb/tb_nat_conn_tracker.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/nat_pkg.sv
// rtl/nat_pkg.sv - shared types and constants for the NAT connection tracker
package nat_pkg;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [7:0]  proto;
    } tuple_t;

    typedef enum logic [1:0] {PASS, LOOKUP, EMIT} state_t;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_TCP      = 8'd6;
    localparam logic [7:0]  PROTO_UDP      = 8'd17;

    localparam logic [2:0] BEAT_ETH   = 3'd1;
    localparam logic [2:0] BEAT_PROTO = 3'd2;
    localparam logic [2:0] BEAT_IP    = 3'd3;
    localparam logic [2:0] BEAT_PORTS = 3'd4;
    localparam logic [2:0] BEAT_BODY  = 3'd5;

    // XOR of the five fields; the caller keeps only the low hash bits
    function automatic logic [31:0] tuple_fold(input tuple_t t);
        return t.src_ip ^ t.dst_ip ^ {16'h0, t.src_port} ^ {16'h0, t.dst_port} ^ {24'h0, t.proto};
    endfunction

endpackage

// File: rtl/nat_conn_tracker_if.sv
// rtl/nat_conn_tracker_if.sv - 64-bit stream interface used on ingress and egress
interface nat_conn_tracker_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/nat_conn_mem.sv
// rtl/nat_conn_mem.sv - connection table: per-slot valid bits, tuple and id
module nat_conn_mem
    import nat_pkg::*;
#(
    parameter int HASH_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [HASH_BITS-1:0] rd_addr_i,
    output logic                 rd_valid_o,
    output tuple_t               rd_tuple_o,
    output logic [HASH_BITS-1:0] rd_id_o,
    input  logic                 wr_en_i,
    input  logic [HASH_BITS-1:0] wr_addr_i,
    input  tuple_t               wr_tuple_i,
    input  logic [HASH_BITS-1:0] wr_id_i
);
    localparam int DEPTH = 1 << HASH_BITS;

    logic [DEPTH-1:0]     valid_q;
    tuple_t               tuple_mem [DEPTH];
    logic [HASH_BITS-1:0] id_mem    [DEPTH];

    // Only the valid bits need clearing; stale keys are never trusted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid_q <= '0;
        else if (flush_i)
            valid_q <= '0;
        else if (wr_en_i)
            valid_q[wr_addr_i] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tuple_mem[wr_addr_i] <= wr_tuple_i;
            id_mem[wr_addr_i]    <= wr_id_i;
        end
    end

    assign rd_valid_o = valid_q[rd_addr_i];
    assign rd_tuple_o = tuple_mem[rd_addr_i];
    assign rd_id_o    = id_mem[rd_addr_i];
endmodule

// File: rtl/nat_conn_tracker.sv
// rtl/nat_conn_tracker.sv - stream passthrough that assigns connection ids to TCP/UDP flows
module nat_conn_tracker
    import nat_pkg::*;
#(
    parameter int HASH_BITS = 6,
    parameter int MAX_PROBE = 8,
    parameter int TRACK_UDP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    nat_conn_tracker_if.slave    s_axis,
    nat_conn_tracker_if.master   m_axis,
    input  logic                 flush,
    output logic [HASH_BITS:0]   conn_count,
    output logic [15:0]          miss_count
);
    localparam int PW = $clog2(MAX_PROBE + 1);

    state_t               state_q, state_d;
    logic [2:0]           beat_q, beat_d;
    logic                 ipv4_q, ipv4_d;
    logic [7:0]           proto_q, proto_d;
    logic [31:0]          src_ip_q, src_ip_d;
    logic [15:0]          dst_lo_q, dst_lo_d;
    tuple_t               tuple_q, tuple_d;
    logic [HASH_BITS-1:0] slot_q, slot_d;
    logic [HASH_BITS-1:0] next_id_q, next_id_d;
    logic [PW-1:0]        probe_q, probe_d;
    logic [HASH_BITS:0]   conn_q, conn_d;
    logic [15:0]          miss_q, miss_d;
    logic [63:0]          data_q, data_d;
    logic [7:0]           keep_q, keep_d;
    logic                 last_q, last_d;
    logic                 valid_q, valid_d;

    logic                 s_fire, tracked_proto, wr_en, mem_flush;
    tuple_t               cur_tuple, rd_tuple;
    logic [HASH_BITS-1:0] cur_slot, rd_id;
    logic                 rd_valid;

    assign s_axis.tready = !rst && (state_q == PASS) && (!valid_q || m_axis.tready);
    assign s_fire        = s_axis.tvalid && s_axis.tready;
    assign tracked_proto = (proto_q == PROTO_TCP) || ((TRACK_UDP != 0) && (proto_q == PROTO_UDP));
    assign cur_tuple     = {src_ip_q, s_axis.tdata[15:0], dst_lo_q,
                            s_axis.tdata[31:16], s_axis.tdata[47:32], proto_q};
    assign cur_slot      = HASH_BITS'(tuple_fold(cur_tuple));

    nat_conn_mem #(.HASH_BITS(HASH_BITS)) u_mem (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (mem_flush),
        .rd_addr_i  (slot_q),
        .rd_valid_o (rd_valid),
        .rd_tuple_o (rd_tuple),
        .rd_id_o    (rd_id),
        .wr_en_i    (wr_en),
        .wr_addr_i  (slot_q),
        .wr_tuple_i (tuple_q),
        .wr_id_i    (next_id_q)
    );

    always_comb begin
        state_d = state_q;  beat_d = beat_q;   ipv4_d = ipv4_q;   proto_d = proto_q;
        src_ip_d = src_ip_q; dst_lo_d = dst_lo_q; tuple_d = tuple_q; slot_d = slot_q;
        next_id_d = next_id_q; probe_d = probe_q; conn_d = conn_q; miss_d = miss_q;
        data_d = data_q;    keep_d = keep_q;   last_d = last_q;
        valid_d = valid_q && !m_axis.tready;
        wr_en = 1'b0;
        mem_flush = 1'b0;
        case (state_q)
            PASS: begin
                if (s_fire) begin
                    data_d  = s_axis.tdata;
                    keep_d  = s_axis.tkeep;
                    last_d  = s_axis.tlast;
                    valid_d = 1'b1;
                    beat_d  = s_axis.tlast ? 3'd0 :
                              (beat_q == BEAT_BODY) ? BEAT_BODY : beat_q + 3'd1;
                    case (beat_q)
                        BEAT_ETH:   ipv4_d  = ({s_axis.tdata[39:32], s_axis.tdata[47:40]} == ETHERTYPE_IPV4);
                        BEAT_PROTO: proto_d = s_axis.tdata[63:56];
                        BEAT_IP: begin
                            src_ip_d = s_axis.tdata[47:16];
                            dst_lo_d = s_axis.tdata[63:48];
                        end
                        BEAT_PORTS: begin
                            // Hold the port beat back until the lookup decides its id
                            if (ipv4_q && tracked_proto && !flush) begin
                                valid_d = 1'b0;
                                tuple_d = cur_tuple;
                                slot_d  = cur_slot;
                                probe_d = '0;
                                state_d = LOOKUP;
                            end
                        end
                        default: ;
                    endcase
                end
                if (flush) begin
                    mem_flush = 1'b1;
                    next_id_d = '0;
                    conn_d    = '0;
                    beat_d    = '0;
                end
            end
            LOOKUP: begin
                if (rd_valid && (rd_tuple == tuple_q)) begin
                    data_d[47:32] = 16'(rd_id);
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else if (!rd_valid) begin
                    wr_en = 1'b1;
                    data_d[47:32] = 16'(next_id_q);
                    next_id_d = next_id_q + HASH_BITS'(1);
                    conn_d  = conn_q + (HASH_BITS+1)'(1);
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else if (probe_q == PW'(MAX_PROBE - 1)) begin
                    miss_d  = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else begin
                    probe_d = probe_q + PW'(1);
                    slot_d  = slot_q + HASH_BITS'(1);
                end
            end
            EMIT: begin
                if (m_axis.tready)
                    state_d = PASS;
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PASS;  beat_q <= '0;   ipv4_q <= 1'b0;  proto_q <= '0;
            src_ip_q <= '0;   dst_lo_q <= '0; tuple_q <= '0;   slot_q <= '0;
            next_id_q <= '0;  probe_q <= '0;  conn_q <= '0;    miss_q <= '0;
            data_q <= '0;     keep_q <= '0;   last_q <= 1'b0;  valid_q <= 1'b0;
        end else begin
            state_q <= state_d;  beat_q <= beat_d;     ipv4_q <= ipv4_d;    proto_q <= proto_d;
            src_ip_q <= src_ip_d; dst_lo_q <= dst_lo_d; tuple_q <= tuple_d; slot_q <= slot_d;
            next_id_q <= next_id_d; probe_q <= probe_d; conn_q <= conn_d;   miss_q <= miss_d;
            data_q <= data_d;    keep_q <= keep_d;     last_q <= last_d;    valid_q <= valid_d;
        end
    end

    assign m_axis.tdata  = data_q;
    assign m_axis.tkeep  = keep_q;
    assign m_axis.tlast  = last_q;
    assign m_axis.tvalid = valid_q;
    assign conn_count    = conn_q;
    assign miss_count    = miss_q;
endmodule

// File: tb/tb_nat_conn_tracker.sv
// tb/tb_nat_conn_tracker.sv - scoreboard bench for nat_conn_tracker
module tb_nat_conn_tracker;
    import nat_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [6:0]  conn_count;
    logic [15:0] miss_count;
    beat_t       sb[$];
    int          vectors = 0;
    int          errors = 0;

    nat_conn_tracker_if s_if();
    nat_conn_tracker_if m_if();

    nat_conn_tracker #(.HASH_BITS(6), .MAX_PROBE(8), .TRACK_UDP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .flush      (flush),
        .conn_count (conn_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (m_if.tvalid && m_if.tready) begin
            check("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("tdata", m_if.tdata, e.data);
                check("tkeep", 64'(m_if.tkeep), 64'(e.keep));
                check("tlast", 64'(m_if.tlast), 64'(e.last));
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_m_tvalid"}, 64'(m_if.tvalid), 64'd0);
        check({tag, "_m_tdata"},  m_if.tdata, 64'd0);
        check({tag, "_m_tkeep"},  64'(m_if.tkeep), 64'd0);
        check({tag, "_m_tlast"},  64'(m_if.tlast), 64'd0);
        check({tag, "_s_tready"}, 64'(s_if.tready), 64'd0);
        check({tag, "_conn"},     64'(conn_count), 64'd0);
        check({tag, "_miss"},     64'(miss_count), 64'd0);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ingress_accept_in_time", 64'(n < 200), 64'd1);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    // exp_id < 0: beat 4 must come out unmodified; exp_lat is the beat-4 latency in cycles
    task automatic send_pkt(input logic [31:0] sip, input logic [31:0] dip,
                            input logic [15:0] sp, input logic [15:0] dp,
                            input logic [7:0] pr, input logic [15:0] et,
                            input int exp_id, input int exp_lat, input bit abort);
        logic [63:0] b [6];
        beat_t e;
        int lat;
        for (int i = 0; i < 6; i++) b[i] = {$urandom, $urandom};
        b[1][39:32] = et[15:8];
        b[1][47:40] = et[7:0];
        b[2][63:56] = pr;
        b[3][47:16] = sip;
        b[3][63:48] = dip[15:0];
        b[4][15:0]  = dip[31:16];
        b[4][31:16] = sp;
        b[4][47:32] = dp;
        for (int i = 0; i < 6; i++) begin
            e.data = b[i];
            e.keep = (i == 5) ? 8'h0F : 8'hFF;
            e.last = (i == 5);
            if (i == 4 && exp_id >= 0) e.data[47:32] = 16'(exp_id);
            sb.push_back(e);
            send_beat(b[i], e.keep, e.last);
            if (i == 4) begin
                if (abort) begin
                    rst = 1'b1;
                    sb.delete();
                    return;
                end
                lat = 1;
                while (!m_if.tvalid && lat < 100) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check("beat4_latency", 64'(lat), 64'(exp_lat));
            end
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 10.0.0.1 -> 10.0.0.2 : 1234 -> 80 hashes to slot 7
        send_pkt(32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, PROTO_TCP, ETHERTYPE_IPV4, 0, 2, 1'b0);
        check("conn_after_first", 64'(conn_count), 64'd1);
        send_pkt(32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, PROTO_TCP, ETHERTYPE_IPV4, 0, 2, 1'b0);
        send_pkt(32'h0A000001, 32'h0A000002, 16'd1235, 16'd80, PROTO_TCP, ETHERTYPE_IPV4, 1, 2, 1'b0);
        check("conn_after_second", 64'(conn_count), 64'd2);

        send_pkt(32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, PROTO_TCP, 16'h0806, -1, 1, 1'b0);
        fork
            send_pkt(32'h0A000001, 32'h0A000002, 16'd7, 16'd9, 8'd1, ETHERTYPE_IPV4, -1, 1, 1'b0);
            begin
                @(posedge clk);
                #1 m_if.tready = 1'b0;
                repeat (5) @(posedge clk);
                #1 m_if.tready = 1'b1;
            end
        join
        check("conn_after_untracked", 64'(conn_count), 64'd2);

        send_pkt(32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, PROTO_UDP, ETHERTYPE_IPV4, 2, 2, 1'b0);
        check("conn_after_udp", 64'(conn_count), 64'd3);

        send_pkt(32'hC0A80001, 32'hC0A80002, 16'd999, 16'd443, PROTO_TCP, ETHERTYPE_IPV4, -1, 0, 1'b1);
        #1;
        check_reset("rst_lookup");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        send_pkt(32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, PROTO_TCP, ETHERTYPE_IPV4, 0, 2, 1'b0);
        send_pkt(32'h0A000001, 32'h0A000002, 16'd1235, 16'd80, PROTO_TCP, ETHERTYPE_IPV4, 1, 2, 1'b0);
        check("conn_populated", 64'(conn_count), 64'd2);
        do_flush();
        check("conn_after_flush", 64'(conn_count), 64'd0);

        // Both hash to slot 63; the second wraps to slot 0
        send_pkt(32'h0A000001, 32'h0A000002, 16'd1234, 16'd40, PROTO_TCP, ETHERTYPE_IPV4, 0, 2, 1'b0);
        send_pkt(32'h0A000101, 32'h0A000002, 16'd1234, 16'd40, PROTO_TCP, ETHERTYPE_IPV4, 1, 3, 1'b0);
        check("conn_after_wrap", 64'(conn_count), 64'd2);

        do_flush();
        for (int i = 0; i < 64; i++)
            send_pkt(32'h0A000001, 32'h0A000002, 16'd1234, 16'(i), PROTO_TCP, ETHERTYPE_IPV4, i, 2, 1'b0);
        check("conn_full", 64'(conn_count), 64'd64);
        send_pkt(32'h0A000001, 32'h0A000002, 16'd1234, 16'd64, PROTO_TCP, ETHERTYPE_IPV4, -1, 9, 1'b0);
        check("miss_when_full", 64'(miss_count), 64'd1);
        check("conn_still_full", 64'(conn_count), 64'd64);
        send_pkt(32'h0A000001, 32'h0A000002, 16'd1234, 16'd5, PROTO_TCP, ETHERTYPE_IPV4, 5, 2, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
